bus_burst_target: RTL and testbench
===================================

// Module: bus_burst_target
// PURPOSE
//  Word-addressed burst memory target on the shared bus; downstream consumer of the DMA controller's bus master port.
//  Accepts single-cycle begin_transaction headers, then sinks write beats or sources read beats from a 32-bit SRAM array.
//  Signals range/alignment faults on busOut_error.
// PARAMETERS
//  BASE_ADDR    32'h5000_0000  byte address of word 0
//  MEM_WORDS    512            array depth in 32-bit words (power of 2)
//  WAIT_CYCLES  1              read latency from header to first beat (>=1)
// PORTS
//  clock                     in   1   rising-edge clock
//  reset                     in   1   synchronous, active-high
//  busIn_address_data        in   32  header: byte address; write beats: data
//  busIn_burst_size          in   8   beats-1, sampled with header
//  busIn_read_n_write        in   1   1=read, 0=write, sampled with header
//  busIn_begin_transaction   in   1   header strobe, one cycle
//  busIn_data_valid          in   1   master write beat valid
//  busIn_end_transaction     in   1   master ends write / aborts read
//  busOut_address_data       out  32  read data (0 when not valid)
//  busOut_data_valid         out  1   read beat valid
//  busOut_end_transaction    out  1   one-cycle pulse after last read beat
//  busOut_busy               out  1   write stall; beat presented while high is not taken
//  busOut_error              out  1   one-cycle fault pulse
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; counters 0; SRAM contents NOT cleared. Reset mid-burst aborts it immediately.
//  - States: IDLE, WRITE, READ_WAIT, READ, READ_END, ERROR.
//  - IDLE: on begin_transaction latch addr, N=burst_size+1, rnw.
//    Fault if addr[1:0]!=0, addr<BASE_ADDR, or idx+N>MEM_WORDS, where idx=(addr-BASE_ADDR)>>2 in 33-bit arithmetic.
//    Fault -> ERROR; else rnw ? READ_WAIT : WRITE.
//  - ERROR: busOut_error=1 for exactly one cycle -> IDLE. No SRAM access occurs.
//  - WRITE: beat accepted when data_valid && !busy.
//    Accepted beat writes SRAM[idx+beat]; beat counter increments.
//    Beats beyond N are ignored (no write).
//    busIn_end_transaction -> IDLE in the same cycle; a beat valid in that cycle is still accepted.
//  - READ_WAIT: waits WAIT_CYCLES cycles, pre-fetching word 0 -> READ.
//    First data_valid occurs at T+1+WAIT_CYCLES, where header is sampled at cycle T.
//  - READ: data_valid=1 on N consecutive cycles; data=SRAM[idx], SRAM[idx+1], ...
//    After the last beat -> READ_END.
//  - READ_END: busOut_end_transaction=1 for one cycle -> IDLE.
//  - busIn_end_transaction in READ_WAIT/READ aborts to IDLE; no end pulse is issued.
//  - begin_transaction outside IDLE is ignored.
//  - Header N=256 (burst_size=255) is legal; the beat counter is 9 bits.
//  - busy=0 at all times unless TARGET_BUSY_INJECT_EN is defined.
// CONFIGURATION
//  TARGET_BUSY_INJECT_EN defined:
//    busy is registered; it asserts for one cycle following every 4th accepted write beat (after beats 4, 8, ...).
//    The master holds data through the busy cycle.
//    busy clears on leaving WRITE.
//  TARGET_BUSY_INJECT_EN undefined: busy tied to 0, with no stall logic.
// TESTING
//  1. Write header BASE, bs=3; beats A0..A3; end -> SRAM[0..3]=A0..A3, no error.
//  2. Read header BASE, bs=3 at T -> data_valid T+2..T+5 = A0..A3; end pulse T+6.
//  3. Header BASE+0x7FC, bs=1 -> error pulse at T+1; no data_valid; SRAM unchanged.
//     Also: address BASE+2 -> error.
//  4. Read bs=0 at BASE+8 -> single beat SRAM[2]; then end pulse.
//     Reset asserted mid-read -> outputs 0 next cycle; new read succeeds.
//  5. With TARGET_BUSY_INJECT_EN: write bs=7 streaming -> busy high the cycle after beats 4 and 8.
//     All 8 words stored exactly once.

Source files
------------

// File: rtl/bus_burst_target.sv
// Word-addressed burst memory target: sinks write bursts into and sources read bursts from a 32-bit SRAM.
// Optional macro TARGET_BUSY_INJECT_EN enables a one-cycle write stall after every 4th accepted beat.
module bus_burst_target #(
    parameter logic [31:0] BASE_ADDR   = 32'h5000_0000,
    parameter int unsigned MEM_WORDS   = 512,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] busIn_address_data,
    input  logic [7:0]  busIn_burst_size,
    input  logic        busIn_read_n_write,
    input  logic        busIn_begin_transaction,
    input  logic        busIn_data_valid,
    input  logic        busIn_end_transaction,
    output logic [31:0] busOut_address_data,
    output logic        busOut_data_valid,
    output logic        busOut_end_transaction,
    output logic        busOut_busy,
    output logic        busOut_error
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned BW = 9;
    localparam int unsigned WW = $clog2(WAIT_CYCLES + 1);
    localparam int unsigned DW = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ_WAIT = 3'd2,
        READ      = 3'd3,
        READ_END  = 3'd4,
        ERROR     = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [BW-1:0]   len_q, len_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [DW-1:0]   rd_data_q;
    logic            valid_q, valid_d;
    logic            end_q, end_d;
    logic            err_q, err_d;

    logic [DW-1:0]   mem_q [MEM_WORDS];
    logic [AW-1:0]   mem_addr_c;
    logic            wr_en_c;
    logic            rd_en_c;
    logic            stall_c;
    logic            accept_c;

    // Header decode in 33-bit arithmetic so addresses below the base show up as a borrow
    logic [32:0]     hdr_off_c;
    logic [32:0]     hdr_idx_c;
    logic [BW-1:0]   hdr_len_c;
    logic            hdr_fault_c;

    assign hdr_off_c   = {1'b0, busIn_address_data} - {1'b0, BASE_ADDR};
    assign hdr_idx_c   = hdr_off_c >> 2;
    assign hdr_len_c   = BW'(busIn_burst_size) + BW'(1);
    assign hdr_fault_c = (busIn_address_data[1:0] != 2'b00) || hdr_off_c[32] ||
                         ((hdr_idx_c + 33'(hdr_len_c)) > 33'(MEM_WORDS));

    assign accept_c   = (state_q == WRITE) && busIn_data_valid && !stall_c;
    assign mem_addr_c = idx_q + AW'(beat_q);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (busIn_begin_transaction) begin
                    if (hdr_fault_c)             state_d = ERROR;
                    else if (busIn_read_n_write) state_d = READ_WAIT;
                    else                         state_d = WRITE;
                end
            end
            WRITE: begin
                if (busIn_end_transaction) state_d = IDLE;
            end
            READ_WAIT: begin
                if (busIn_end_transaction)                 state_d = IDLE;
                else if (wait_q == WW'(WAIT_CYCLES - 1))   state_d = READ;
            end
            READ: begin
                if (busIn_end_transaction)  state_d = IDLE;
                else if (beat_q == len_q)   state_d = READ_END;
            end
            READ_END: state_d = IDLE;
            ERROR:    state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output and datapath logic; beat_q counts beats already written or launched
    always_comb begin
        idx_d   = idx_q;
        len_d   = len_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        wr_en_c = 1'b0;
        rd_en_c = 1'b0;
        valid_d = (state_d == READ);
        end_d   = (state_d == READ_END);
        err_d   = (state_d == ERROR);
        case (state_q)
            IDLE: begin
                if (busIn_begin_transaction) begin
                    idx_d  = AW'(hdr_idx_c);
                    len_d  = hdr_len_c;
                    beat_d = '0;
                    wait_d = '0;
                end
            end
            WRITE: begin
                if (accept_c && (beat_q < len_q)) begin
                    wr_en_c = !reset;
                    beat_d  = beat_q + BW'(1);
                end
            end
            READ_WAIT: wait_d = wait_q + WW'(1);
            default: ;
        endcase
        if (state_d == READ) begin
            rd_en_c = 1'b1;
            beat_d  = beat_q + BW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q     <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            wait_q    <= '0;
            rd_data_q <= '0;
            valid_q   <= 1'b0;
            end_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            wait_q    <= wait_d;
            rd_data_q <= rd_en_c ? mem_q[mem_addr_c] : '0;
            valid_q   <= valid_d;
            end_q     <= end_d;
            err_q     <= err_d;
        end
    end

    // SRAM array is never cleared by reset
    always_ff @(posedge clock) begin
        if (wr_en_c) begin
            mem_q[mem_addr_c] <= busIn_address_data;
        end
    end

`ifdef TARGET_BUSY_INJECT_EN
    logic       busy_q, busy_d;
    logic [1:0] acc_q, acc_d;

    assign stall_c = busy_q;

    // Stall for one cycle after every 4th accepted beat while still in WRITE
    always_comb begin
        acc_d  = acc_q;
        busy_d = 1'b0;
        if (state_q == IDLE) begin
            acc_d = '0;
        end else if (accept_c) begin
            acc_d  = acc_q + 2'd1;
            busy_d = (acc_q == 2'd3) && (state_d == WRITE);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= 1'b0;
            acc_q  <= '0;
        end else begin
            busy_q <= busy_d;
            acc_q  <= acc_d;
        end
    end

    assign busOut_busy = busy_q;
`else
    assign stall_c     = 1'b0;
    assign busOut_busy = 1'b0;
`endif

    assign busOut_address_data    = rd_data_q;
    assign busOut_data_valid      = valid_q;
    assign busOut_end_transaction = end_q;
    assign busOut_error           = err_q;

endmodule

// File: tb/tb_bus_burst_target.sv
// Directed testbench for bus_burst_target: write/read bursts, faults, reset abort and optional busy stalls.
module tb_bus_burst_target;

    localparam logic [31:0] BASE = 32'h5000_0000;
`ifdef TARGET_BUSY_INJECT_EN
    localparam bit BUSY_EN = 1'b1;
`else
    localparam bit BUSY_EN = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [31:0] busIn_address_data;
    logic [7:0]  busIn_burst_size;
    logic        busIn_read_n_write;
    logic        busIn_begin_transaction;
    logic        busIn_data_valid;
    logic        busIn_end_transaction;
    logic [31:0] busOut_address_data;
    logic        busOut_data_valid;
    logic        busOut_end_transaction;
    logic        busOut_busy;
    logic        busOut_error;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] model [512];
    int          stalls;
    int          stall_beat;

    bus_burst_target dut (
        .clock                   (clock),
        .reset                   (reset),
        .busIn_address_data      (busIn_address_data),
        .busIn_burst_size        (busIn_burst_size),
        .busIn_read_n_write      (busIn_read_n_write),
        .busIn_begin_transaction (busIn_begin_transaction),
        .busIn_data_valid        (busIn_data_valid),
        .busIn_end_transaction   (busIn_end_transaction),
        .busOut_address_data     (busOut_address_data),
        .busOut_data_valid       (busOut_data_valid),
        .busOut_end_transaction  (busOut_end_transaction),
        .busOut_busy             (busOut_busy),
        .busOut_error            (busOut_error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data"},  busOut_address_data, 32'h0);
        check({tag, "_valid"}, 32'(busOut_data_valid), 32'h0);
        check({tag, "_end"},   32'(busOut_end_transaction), 32'h0);
        check({tag, "_busy"},  32'(busOut_busy), 32'h0);
        check({tag, "_err"},   32'(busOut_error), 32'h0);
    endtask

    task automatic send_header(input logic [31:0] addr, input logic [7:0] bs, input logic rnw);
        busIn_address_data      = addr;
        busIn_burst_size        = bs;
        busIn_read_n_write      = rnw;
        busIn_begin_transaction = 1'b1;
        step();
        busIn_begin_transaction = 1'b0;
        busIn_address_data      = 32'h0;
    endtask

    // Streams nbeats words seed+i; holds the current beat (without end) while busy is high
    task automatic write_burst(input logic [31:0] addr, input logic [7:0] bs, input int nbeats,
                               input logic [31:0] seed, input bit do_end,
                               output int n_stalls, output int first_stall);
        int n   = int'(bs) + 1;
        int idx = int'((addr - BASE) >> 2);
        int guard;
        n_stalls    = 0;
        first_stall = -1;
        send_header(addr, bs, 1'b0);
        for (int i = 0; i < nbeats; i++) begin
            guard = 0;
            while (busOut_busy && guard < 4) begin
                busIn_data_valid      = 1'b1;
                busIn_address_data    = seed + 32'(i);
                busIn_end_transaction = 1'b0;
                if (first_stall < 0) first_stall = i;
                n_stalls++;
                guard++;
                step();
            end
            check("wr_stall_bound", 32'(guard < 4), 32'h1);
            check("wr_err", 32'(busOut_error), 32'h0);
            busIn_data_valid      = 1'b1;
            busIn_address_data    = seed + 32'(i);
            busIn_end_transaction = do_end && (i == nbeats - 1);
            if (i < n) model[idx + i] = seed + 32'(i);
            step();
        end
        busIn_data_valid      = 1'b0;
        busIn_end_transaction = 1'b0;
        busIn_address_data    = 32'h0;
    endtask

    // Header at edge T: beats at T+2..T+1+N, end pulse at T+2+N
    task automatic read_burst(input logic [31:0] addr, input logic [7:0] bs, input string tag);
        int  n   = int'(bs) + 1;
        int  idx = int'((addr - BASE) >> 2);
        bit  exp_v;
        send_header(addr, bs, 1'b1);
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clock);
            exp_v = (k >= 2) && (k <= n + 1);
            check($sformatf("%s_valid[%0d]", tag, k), 32'(busOut_data_valid), 32'(exp_v));
            check($sformatf("%s_data[%0d]", tag, k), busOut_address_data,
                  exp_v ? model[idx + k - 2] : 32'h0);
            check($sformatf("%s_end[%0d]", tag, k), 32'(busOut_end_transaction), 32'(k == n + 2));
            step();
        end
    endtask

    // Faulting header; a stray beat during the error cycle must not reach the SRAM
    task automatic err_header(input logic [31:0] addr, input logic [7:0] bs, input logic rnw,
                              input string tag);
        send_header(addr, bs, rnw);
        busIn_data_valid      = 1'b1;
        busIn_address_data    = 32'hDEAD_BEEF;
        busIn_end_transaction = 1'b1;
        @(negedge clock);
        check({tag, "_err_pulse"}, 32'(busOut_error), 32'h1);
        check({tag, "_no_valid"},  32'(busOut_data_valid), 32'h0);
        step();
        busIn_data_valid      = 1'b0;
        busIn_address_data    = 32'h0;
        busIn_end_transaction = 1'b0;
        @(negedge clock);
        check({tag, "_err_clear"}, 32'(busOut_error), 32'h0);
        step();
    endtask

    initial begin
        reset                   = 1'b1;
        busIn_address_data      = 32'h0;
        busIn_burst_size        = 8'h0;
        busIn_read_n_write      = 1'b0;
        busIn_begin_transaction = 1'b0;
        busIn_data_valid        = 1'b0;
        busIn_end_transaction   = 1'b0;
        step();
        step();
        @(negedge clock);
        check_idle_outputs("reset");
        step();
        reset = 1'b0;

        // Basic write then fill the following words
        write_burst(BASE, 8'd3, 4, 32'hA000_0000, 1'b1, stalls, stall_beat);
        check("t1_stalls", 32'(stalls), 32'h0);
        write_burst(BASE + 32'h10, 8'd3, 4, 32'hB000_0000, 1'b1, stalls, stall_beat);
        read_burst(BASE, 8'd3, "t2");

        // Last word is a legal single-beat target
        write_burst(BASE + 32'h7FC, 8'd0, 1, 32'hD000_0000, 1'b1, stalls, stall_beat);
        read_burst(BASE + 32'h7FC, 8'd0, "last_word");

        err_header(BASE + 32'h7FC, 8'd1, 1'b0, "t3_range");
        err_header(BASE + 32'h2, 8'd0, 1'b1, "t3_align");
        err_header(BASE - 32'h4, 8'd0, 1'b1, "t3_below");
        read_burst(BASE + 32'h7FC, 8'd0, "t3_keep");
        read_burst(BASE, 8'd3, "t3_unchanged");

        read_burst(BASE + 32'h8, 8'd0, "t4_single");

        // Reset in the middle of a read burst
        send_header(BASE, 8'd3, 1'b1);
        step();
        step();
        check("t4_midread_valid", 32'(busOut_data_valid), 32'h1);
        reset = 1'b1;
        step();
        @(negedge clock);
        check_idle_outputs("t4_rst");
        reset = 1'b0;
        step();
        read_burst(BASE, 8'd3, "t4_after_reset");

        // Begin inside WRITE is ignored; third beat of a 2-beat write is dropped
        send_header(BASE + 32'h10, 8'd1, 1'b0);
        busIn_begin_transaction = 1'b1;
        busIn_read_n_write      = 1'b1;
        busIn_address_data      = BASE;
        busIn_burst_size        = 8'd3;
        step();
        busIn_begin_transaction = 1'b0;
        busIn_read_n_write      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            busIn_data_valid      = 1'b1;
            busIn_address_data    = 32'hF000_0000 + 32'(i);
            busIn_end_transaction = (i == 2);
            step();
        end
        busIn_data_valid      = 1'b0;
        busIn_end_transaction = 1'b0;
        model[4] = 32'hF000_0000;
        model[5] = 32'hF000_0001;
        read_burst(BASE + 32'h10, 8'd2, "beyond_n");

        // Maximum burst of 256 beats ending at the top of the array
        write_burst(BASE + 32'h400, 8'd255, 256, 32'hC000_0000, 1'b1, stalls, stall_beat);
        check("n256_stalls", 32'(stalls), BUSY_EN ? 32'd63 : 32'd0);
        read_burst(BASE + 32'h400, 8'd255, "n256");

        // 8-beat stream without end: stall after beats 4 and 8 when injection is on
        write_burst(BASE + 32'h20, 8'd7, 8, 32'hE000_0000, 1'b0, stalls, stall_beat);
        check("t5_stalls", 32'(stalls), BUSY_EN ? 32'd1 : 32'd0);
        check("t5_stall_beat", 32'(stall_beat), BUSY_EN ? 32'd4 : 32'hFFFF_FFFF);
        check("t5_busy_after8", 32'(busOut_busy), 32'(BUSY_EN));
        busIn_end_transaction = 1'b1;
        step();
        busIn_end_transaction = 1'b0;
        check("t5_busy_cleared", 32'(busOut_busy), 32'h0);
        read_burst(BASE + 32'h20, 8'd7, "t5_read");
        read_burst(BASE + 32'h10, 8'd3, "t5_neighbours");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
